round_timer: RTL and testbench

Per-round countdown source for the binary counting game. It produces the elapsed-time value, the latched maximum time, and the enable that the LED blink logic consumes. It also reports when the player answered in time or when the round expired. It sits between the game FSM (start/stop/pause commands) and the display/blink path.

---
 rtl/round_timer.sv | 119 +++++++++++
 tb/tb_round_timer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/round_timer.sv
// Per-round countdown source for the binary counting game: elapsed units,
// latched round length, blink enable and answer/expiry reporting.
module round_timer #(
   parameter int unsigned TICK_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [7:0] max_time,
   output logic [7:0] timer_value,
   output logic [7:0] max_time_q,
   output logic       running,
   output logic       paused,
   output logic       tick,
   output logic       timeout,
   output logic       expired
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_PAUSE   = 2'd2;
   localparam logic [1:0] S_EXPIRED = 2'd3;

   localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [7:0]  timer_q, timer_d;
   logic [7:0]  max_lat_q, max_lat_d;
   logic        tick_q, tick_d;
   logic        timeout_q, timeout_d;
   logic        running_q, paused_q, expired_q;

   // Priority: start > stop > pause > prescaler wrap, in every state.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      timer_d   = timer_q;
      max_lat_d = max_lat_q;
      tick_d    = 1'b0;
      timeout_d = 1'b0;
      if (start) begin
         max_lat_d = max_time;
         timer_d   = 8'd0;
         presc_d   = 16'd0;
         if (max_time == 8'd0) begin
            state_d   = S_EXPIRED;
            timeout_d = 1'b1;
         end else begin
            state_d = S_RUN;
         end
      end else begin
         case (state_q)
            S_RUN: begin
               if (stop) begin
                  state_d = S_IDLE;
               end else if (pause) begin
                  state_d = S_PAUSE;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = 16'd0;
                  timer_d = timer_q + 8'd1;
                  tick_d  = 1'b1;
                  if (timer_q + 8'd1 == max_lat_q) begin
                     state_d   = S_EXPIRED;
                     timeout_d = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + 16'd1;
               end
            end
            // The resume edge itself does not advance the prescaler, so the
            // partial unit held during the pause is neither lost nor gained.
            S_PAUSE: begin
               if (stop) begin
                  state_d = S_IDLE;
               end else if (!pause) begin
                  state_d = S_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         presc_q   <= 16'd0;
         timer_q   <= 8'd0;
         max_lat_q <= 8'd0;
         tick_q    <= 1'b0;
         timeout_q <= 1'b0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         timer_q   <= timer_d;
         max_lat_q <= max_lat_d;
         tick_q    <= tick_d;
         timeout_q <= timeout_d;
         running_q <= (state_d == S_RUN);
         paused_q  <= (state_d == S_PAUSE);
         expired_q <= (state_d == S_EXPIRED);
      end
   end

   assign timer_value = timer_q;
   assign max_time_q  = max_lat_q;
   assign running     = running_q;
   assign paused      = paused_q;
   assign tick        = tick_q;
   assign timeout     = timeout_q;
   assign expired     = expired_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: one instance with TICK_DIV=4 and one with
// TICK_DIV=1, driven by the same inputs.
module tb_round_timer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       pause;
   logic [7:0] max_time;

   logic [7:0] tv4, mq4, tv1, mq1;
   logic       run4, pau4, tk4, to4, ex4;
   logic       run1, pau1, tk1, to1, ex1;

   int n_tests;
   int n_fail;

   round_timer #(.TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .max_time(max_time), .timer_value(tv4), .max_time_q(mq4),
      .running(run4), .paused(pau4), .tick(tk4), .timeout(to4), .expired(ex4)
   );

   round_timer #(.TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .max_time(max_time), .timer_value(tv1), .max_time_q(mq1),
      .running(run1), .paused(pau1), .tick(tk1), .timeout(to1), .expired(ex1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_round(input logic [7:0] mt);
      max_time = mt;
      start    = 1'b1;
      cyc();
      start    = 1'b0;
   endtask

   task automatic check_idle4(input string tag, input logic [7:0] tv);
      check_eq({tag, "_tv"}, 16'(tv4), 16'(tv));
      check_eq({tag, "_run"}, 16'(run4), 16'd0);
      check_eq({tag, "_pau"}, 16'(pau4), 16'd0);
      check_eq({tag, "_exp"}, 16'(ex4), 16'd0);
      check_eq({tag, "_to"}, 16'(to4), 16'd0);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      pause    = 1'b0;
      max_time = 8'd0;
      cyc(2);
      rst = 1'b0;

      // Reset state
      check_idle4("rst", 8'd0);
      check_eq("rst_mq", 16'(mq4), 16'd0);
      check_eq("rst_tick", 16'(tk4), 16'd0);

      // 1: natural expiry, ticks every 4 cycles
      start_round(8'd3);
      check_eq("t1_run0", 16'(run4), 16'd1);
      check_eq("t1_mq", 16'(mq4), 16'd3);
      for (int k = 1; k <= 12; k++) begin
         cyc();
         check_eq($sformatf("t1_tick%0d", k), 16'(tk4), 16'((k % 4) == 0));
         check_eq($sformatf("t1_tv%0d", k), 16'(tv4), 16'(k / 4));
         check_eq($sformatf("t1_to%0d", k), 16'(to4), 16'(k == 12));
      end
      check_eq("t1_exp", 16'(ex4), 16'd1);
      check_eq("t1_run", 16'(run4), 16'd0);
      cyc(2);
      check_eq("t1_to_after", 16'(to4), 16'd0);
      check_eq("t1_exp_hold", 16'(ex4), 16'd1);
      check_eq("t1_tv_hold", 16'(tv4), 16'd3);
      stop  = 1'b1;
      pause = 1'b1;
      cyc();
      stop  = 1'b0;
      pause = 1'b0;
      check_eq("t1_exp_ign", 16'(ex4), 16'd1);

      // 2: stop after 9 cycles, then stop/pause ignored in IDLE
      start_round(8'd10);
      cyc(8);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check_idle4("t2", 8'd2);
      stop = 1'b1;
      cyc();
      stop  = 1'b0;
      pause = 1'b1;
      cyc(3);
      check_idle4("t2_ign", 8'd2);
      pause = 1'b0;

      // 3: pause 2 cycles into a unit; 2 cycles remain after release
      start_round(8'd10);
      cyc(2);
      pause = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         check_eq($sformatf("t3_pau%0d", k), 16'(pau4), 16'd1);
         check_eq($sformatf("t3_tv%0d", k), 16'(tv4), 16'd0);
         check_eq($sformatf("t3_tk%0d", k), 16'(tk4), 16'd0);
      end
      check_eq("t3_run_p", 16'(run4), 16'd0);
      pause = 1'b0;
      cyc();
      check_eq("t3_run", 16'(run4), 16'd1);
      check_eq("t3_pau_off", 16'(pau4), 16'd0);
      check_eq("t3_tk_r1", 16'(tk4), 16'd0);
      cyc();
      check_eq("t3_tk_r2", 16'(tk4), 16'd0);
      cyc();
      check_eq("t3_tk_r3", 16'(tk4), 16'd1);
      check_eq("t3_tv_r3", 16'(tv4), 16'd1);

      // 4a: stop on the final tick cycle wins
      start_round(8'd2);
      cyc(7);
      check_eq("t4_tv_pre", 16'(tv4), 16'd1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check_idle4("t4a", 8'd1);
      check_eq("t4a_tick", 16'(tk4), 16'd0);
      cyc(5);
      check_idle4("t4a_late", 8'd1);

      // 4b: start on the final tick cycle restarts
      start_round(8'd2);
      cyc(7);
      start_round(8'd5);
      check_eq("t4b_tv", 16'(tv4), 16'd0);
      check_eq("t4b_mq", 16'(mq4), 16'd5);
      check_eq("t4b_run", 16'(run4), 16'd1);
      check_eq("t4b_to", 16'(to4), 16'd0);
      check_eq("t4b_tick", 16'(tk4), 16'd0);

      // 5: zero-length round, then max_time change mid-round
      start_round(8'd0);
      check_eq("t5_exp", 16'(ex4), 16'd1);
      check_eq("t5_to", 16'(to4), 16'd1);
      check_eq("t5_tv", 16'(tv4), 16'd0);
      check_eq("t5_run", 16'(run4), 16'd0);
      cyc();
      check_eq("t5_to_once", 16'(to4), 16'd0);
      start_round(8'd20);
      max_time = 8'd50;
      cyc(6);
      check_eq("t5_mq", 16'(mq4), 16'd20);
      check_eq("t5_tv6", 16'(tv4), 16'd1);

      // 6a: reset mid-round at timer_value 5
      start_round(8'd20);
      cyc(20);
      check_eq("t6_tv_pre", 16'(tv4), 16'd5);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_idle4("t6_rst", 8'd0);
      check_eq("t6_mq", 16'(mq4), 16'd0);
      check_eq("t6_tick", 16'(tk4), 16'd0);

      // 6b: TICK_DIV=1 increments every RUN cycle
      start_round(8'd5);
      check_eq("t6b_run", 16'(run1), 16'd1);
      check_eq("t6b_tv0", 16'(tv1), 16'd0);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         check_eq($sformatf("t6b_tv%0d", k), 16'(tv1), 16'(k));
         check_eq($sformatf("t6b_tk%0d", k), 16'(tk1), 16'd1);
         check_eq($sformatf("t6b_to%0d", k), 16'(to1), 16'(k == 5));
      end
      check_eq("t6b_exp", 16'(ex1), 16'd1);
      cyc();
      check_eq("t6b_tv_hold", 16'(tv1), 16'd5);
      check_eq("t6b_tk_off", 16'(tk1), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
